// File: rtl/frame_stream_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// frame_stream_arbiter_pkg
// Shared definitions for the frame-aware video stream blocks (arbiter,
// line buffer, Sobel filter).
//   - arb_state_t : arbiter state encoding (IDLE / GRANT0 / GRANT1)
//   - DATA_W_DEFAULT, LINES_DEFAULT, LCNT_W_DEFAULT : default stream geometry
// ----------------------------------------------------------------------------
package frame_stream_arbiter_pkg;

    localparam int DATA_W_DEFAULT = 24;
    localparam int LINES_DEFAULT  = 480;
    localparam int LCNT_W_DEFAULT = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/frame_stream_arbiter_line_counter.sv
// ----------------------------------------------------------------------------
// frame_line_counter
// Counts tlast beats of the frame currently flowing through a stream port and
// flags frame structure events.
//   aclk, aresetn : clock, asynchronous active-low reset
//   beat_valid    : a beat is accepted this cycle (tvalid && tready)
//   beat_tuser    : tuser of the accepted beat
//   beat_tlast    : tlast of the accepted beat
//   frame_end     : accepted beat is the final tlast of the frame (combinational)
//   sof_err       : accepted beat carries tuser in the middle of a frame
//                   (combinational)
// ----------------------------------------------------------------------------
module frame_line_counter
    import frame_stream_arbiter_pkg::*;
#(
    parameter int LINES  = LINES_DEFAULT,
    parameter int LCNT_W = LCNT_W_DEFAULT
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic beat_valid,
    input  logic beat_tuser,
    input  logic beat_tlast,
    output logic frame_end,
    output logic sof_err
);

    localparam logic [LCNT_W-1:0] LAST_LINE = LCNT_W'(LINES - 1);

    logic [LCNT_W-1:0] line_cnt;
    logic              in_frame;
    logic [LCNT_W-1:0] line_base;

    // A tuser is only legal on the very first beat of a frame. A stray tuser
    // restarts the count, so the beat is evaluated against line 0; this also
    // makes a tuser+tlast beat count as the first line of the new frame.
    always_comb begin
        sof_err   = beat_valid && beat_tuser && ((line_cnt != '0) || in_frame);
        line_base = sof_err ? '0 : line_cnt;
        frame_end = beat_valid && beat_tlast && (line_base == LAST_LINE);
    end

    // in_frame remembers that some beat of the current frame has already
    // been accepted, which catches a repeated tuser within line 0.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            line_cnt <= '0;
            in_frame <= 1'b0;
        end else if (frame_end) begin
            line_cnt <= '0;
            in_frame <= 1'b0;
        end else if (beat_valid) begin
            line_cnt <= beat_tlast ? line_base + 1'b1 : line_base;
            in_frame <= 1'b1;
        end
    end

endmodule

// File: rtl/frame_stream_arbiter.sv
// ----------------------------------------------------------------------------
// frame_stream_arbiter
// Shares one downstream RGB-to-grey converter between two AXI4-Stream video
// sources, switching only at frame boundaries (round-robin).
//   aclk, aresetn   : clock, asynchronous active-low reset
//   enable          : 1 = new grants allowed; 0 = finish frame, then idle
//   s0_axis_*       : source 0 stream (tvalid/tready/tuser/tlast/tdata)
//   s1_axis_*       : source 1 stream
//   m_axis_*        : stream towards the converter
//   active_src      : source of the current or last granted frame
//   busy            : a frame is granted
//   frame_done      : one-cycle pulse after the final tlast of a frame
//   sync_err        : one-cycle pulse on mid-frame tuser or flushed beat
// ----------------------------------------------------------------------------
module frame_stream_arbiter
    import frame_stream_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int LINES  = LINES_DEFAULT,
    parameter int LCNT_W = LCNT_W_DEFAULT
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              enable,
    input  logic              s0_axis_tvalid,
    output logic              s0_axis_tready,
    input  logic              s0_axis_tuser,
    input  logic              s0_axis_tlast,
    input  logic [DATA_W-1:0] s0_axis_tdata,
    input  logic              s1_axis_tvalid,
    output logic              s1_axis_tready,
    input  logic              s1_axis_tuser,
    input  logic              s1_axis_tlast,
    input  logic [DATA_W-1:0] s1_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tuser,
    output logic              m_axis_tlast,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              active_src,
    output logic              busy,
    output logic              frame_done,
    output logic              sync_err
);

    arb_state_t state;
    logic       last_grant;
    logic       req0, req1;
    logic       flush0, flush1;
    logic       grant_pick;
    logic       beat_acc;
    logic       frame_end;
    logic       sof_err;

    // Requests are start-of-frame beats. Anything else waiting while idle is
    // the tail of a frame we never saw the start of, so it is drained. The
    // reset term keeps every tready low while reset is held.
    always_comb begin
        req0       = s0_axis_tvalid && s0_axis_tuser;
        req1       = s1_axis_tvalid && s1_axis_tuser;
        flush0     = aresetn && (state == IDLE) && s0_axis_tvalid && !s0_axis_tuser;
        flush1     = aresetn && (state == IDLE) && s1_axis_tvalid && !s1_axis_tuser;
        grant_pick = (req0 && req1) ? ~last_grant : req1;
        busy       = (state != IDLE);
        beat_acc   = m_axis_tvalid && m_axis_tready;
    end

    // Zero-latency datapath mux; the losing source is back-pressured.
    always_comb begin
        m_axis_tvalid  = 1'b0;
        m_axis_tuser   = 1'b0;
        m_axis_tlast   = 1'b0;
        m_axis_tdata   = '0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        case (state)
            GRANT0: begin
                m_axis_tvalid  = s0_axis_tvalid;
                m_axis_tuser   = s0_axis_tuser;
                m_axis_tlast   = s0_axis_tlast;
                m_axis_tdata   = s0_axis_tdata;
                s0_axis_tready = m_axis_tready;
            end
            GRANT1: begin
                m_axis_tvalid  = s1_axis_tvalid;
                m_axis_tuser   = s1_axis_tuser;
                m_axis_tlast   = s1_axis_tlast;
                m_axis_tdata   = s1_axis_tdata;
                s1_axis_tready = m_axis_tready;
            end
            default: begin
                s0_axis_tready = flush0;
                s1_axis_tready = flush1;
            end
        endcase
    end

    frame_line_counter #(
        .LINES  (LINES),
        .LCNT_W (LCNT_W)
    ) u_line_counter (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .beat_valid (beat_acc),
        .beat_tuser (m_axis_tuser),
        .beat_tlast (m_axis_tlast),
        .frame_end  (frame_end),
        .sof_err    (sof_err)
    );

    // Grant FSM: the decision cycle transfers nothing; the grant is held
    // until the frame's final line, regardless of enable.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            active_src <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            frame_done <= frame_end;
            sync_err   <= sof_err || flush0 || flush1;
            case (state)
                IDLE: begin
                    if (enable && (req0 || req1)) begin
                        state      <= grant_pick ? GRANT1 : GRANT0;
                        last_grant <= grant_pick;
                        active_src <= grant_pick;
                    end
                end
                GRANT0, GRANT1: begin
                    if (frame_end) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
